regfile_wb_queue: RTL

REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

---
 rtl/regfile_wb_pkg.sv | 21 ++
 rtl/regfile_wb_bypass.sv | 38 +++
 rtl/regfile_wb_queue.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file write-back queue: entry payload, address width
// and the core configuration record that supplies the commit port count.
package regfile_wb_pkg;

  localparam int unsigned REG_ADDR_WIDTH    = 5;
  localparam int unsigned WB_MAX_DATA_WIDTH = 64;

  // Entry payload; data is held at the widest supported register width.
  typedef struct packed {
    logic                         valid;
    logic [REG_ADDR_WIDTH-1:0]    addr;
    logic [WB_MAX_DATA_WIDTH-1:0] data;
  } wb_entry_t;

  typedef struct packed {
    int unsigned NrCommitPorts;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 2};

endpackage

// File: rtl/regfile_wb_bypass.sv
// Youngest-match search of pending write-back entries for each operand read port.
// Only built when REGFILE_WB_BYPASS_EN is defined.
`ifdef REGFILE_WB_BYPASS_EN
module regfile_wb_bypass
  import regfile_wb_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH    = 32,
  parameter  int unsigned DEPTH         = 4,
  parameter  int unsigned NR_READ_PORTS = 2,
  localparam int unsigned PTR_W         = $clog2(DEPTH)
) (
  input  wb_entry_t                                        entries_i [DEPTH],
  input  logic [PTR_W-1:0]                                 head_i,
  input  logic [NR_READ_PORTS-1:0][REG_ADDR_WIDTH-1:0]     raddr_i,
  output logic [NR_READ_PORTS-1:0]                         hit_o,
  output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]         data_o
);

  logic [PTR_W-1:0] slot_c;

  // Walk entries oldest to youngest so the last match wins.
  always_comb begin
    hit_o  = '0;
    data_o = '0;
    slot_c = '0;
    for (int unsigned r = 0; r < NR_READ_PORTS; r++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        slot_c = head_i + PTR_W'(j);
        if (entries_i[slot_c].valid && (entries_i[slot_c].addr == raddr_i[r])) begin
          hit_o[r]  = 1'b1;
          data_o[r] = DATA_WIDTH'(entries_i[slot_c].data);
        end
      end
    end
  end

endmodule
`endif

// File: rtl/regfile_wb_queue.sv
// Write-back queue between the commit stage and the register file, with optional
// operand bypass of pending writes (enabled by macro REGFILE_WB_BYPASS_EN).
module regfile_wb_queue
  import regfile_wb_pkg::*;
#(
  parameter  cva6_cfg_t   CVA6Cfg       = cva6_cfg_empty,
  parameter  int unsigned DATA_WIDTH    = 32,
  parameter  int unsigned DEPTH         = 4,
  parameter  int unsigned NR_READ_PORTS = 2,
  parameter  bit          ZERO_REG_ZERO = 1'b0,
  localparam int unsigned NCP           = CVA6Cfg.NrCommitPorts,
  localparam int unsigned PTR_W         = $clog2(DEPTH),
  localparam int unsigned CNT_W         = $clog2(DEPTH) + 1
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic [NCP-1:0]                               commit_we_i,
  input  logic [NCP-1:0][REG_ADDR_WIDTH-1:0]           commit_waddr_i,
  input  logic [NCP-1:0][DATA_WIDTH-1:0]               commit_wdata_i,
  output logic                                         commit_ready_o,
  input  logic                                         rf_ready_i,
  output logic [NCP-1:0]                               rf_we_o,
  output logic [NCP-1:0][REG_ADDR_WIDTH-1:0]           rf_waddr_o,
  output logic [NCP-1:0][DATA_WIDTH-1:0]               rf_wdata_o,
  input  logic [NR_READ_PORTS-1:0][REG_ADDR_WIDTH-1:0] byp_raddr_i,
  output logic [NR_READ_PORTS-1:0]                     byp_hit_o,
  output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]     byp_data_o,
  output logic [CNT_W-1:0]                             count_o,
  output logic                                         empty_o
);

  logic [PTR_W-1:0]          head_q, head_d;
  logic [PTR_W-1:0]          tail_q, tail_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [DEPTH-1:0]          valid_q, valid_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [DATA_WIDTH-1:0]     data_q [DEPTH];
  logic [DATA_WIDTH-1:0]     data_d [DEPTH];

  logic [NCP-1:0]            enq_we_c;
  logic [CNT_W-1:0]          n_enq_c;
  logic [CNT_W-1:0]          n_deq_c;
  logic [PTR_W-1:0]          enq_slot_c;
  logic [PTR_W-1:0]          deq_slot_c;
  logic [PTR_W-1:0]          out_slot_c;
  wb_entry_t                 entry_c [DEPTH];

  // Space check uses only the registered count; a drain in the same cycle is not credited.
  assign commit_ready_o = rst_ni && ((CNT_W'(DEPTH) - count_q) >= CNT_W'(NCP));
  assign count_o        = count_q;
  assign empty_o        = (count_q == '0);

  always_comb begin
    enq_we_c = '0;
    for (int unsigned p = 0; p < NCP; p++) begin
      enq_we_c[p] = commit_ready_o && commit_we_i[p]
                    && !(ZERO_REG_ZERO && (commit_waddr_i[p] == '0));
    end
  end

  // Pointer, occupancy and storage update: pop from head, push packed at tail.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    valid_d    = valid_q;
    addr_d     = addr_q;
    data_d     = data_q;
    n_enq_c    = '0;
    n_deq_c    = '0;
    enq_slot_c = '0;
    deq_slot_c = '0;

    if (rf_ready_i) begin
      n_deq_c = (count_q < CNT_W'(NCP)) ? count_q : CNT_W'(NCP);
    end
    for (int unsigned k = 0; k < NCP; k++) begin
      if (CNT_W'(k) < n_deq_c) begin
        deq_slot_c          = head_q + PTR_W'(k);
        valid_d[deq_slot_c] = 1'b0;
      end
    end

    // Ready guarantees the tail slots are free, so they never alias popped slots.
    for (int unsigned p = 0; p < NCP; p++) begin
      if (enq_we_c[p]) begin
        enq_slot_c          = tail_q + PTR_W'(n_enq_c);
        valid_d[enq_slot_c] = 1'b1;
        addr_d[enq_slot_c]  = commit_waddr_i[p];
        data_d[enq_slot_c]  = commit_wdata_i[p];
        n_enq_c             = n_enq_c + CNT_W'(1);
      end
    end

    head_d  = head_q + PTR_W'(n_deq_c);
    tail_d  = tail_q + PTR_W'(n_enq_c);
    count_d = count_q + n_enq_c - n_deq_c;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_c[i].valid = valid_q[i];
      entry_c[i].addr  = addr_q[i];
      entry_c[i].data  = WB_MAX_DATA_WIDTH'(data_q[i]);
    end
  end

  // Register-file ports present the oldest entries, port 0 oldest.
  always_comb begin
    rf_we_o    = '0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    out_slot_c = '0;
    for (int unsigned k = 0; k < NCP; k++) begin
      out_slot_c    = head_q + PTR_W'(k);
      rf_we_o[k]    = rf_ready_i && (CNT_W'(k) < count_q) && entry_c[out_slot_c].valid;
      rf_waddr_o[k] = entry_c[out_slot_c].addr;
      rf_wdata_o[k] = DATA_WIDTH'(entry_c[out_slot_c].data);
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  regfile_wb_bypass #(
    .DATA_WIDTH    (DATA_WIDTH),
    .DEPTH         (DEPTH),
    .NR_READ_PORTS (NR_READ_PORTS)
  ) u_bypass (
    .entries_i (entry_c),
    .head_i    (head_q),
    .raddr_i   (byp_raddr_i),
    .hit_o     (byp_hit_o),
    .data_o    (byp_data_o)
  );
`else
  // Without bypass the reader stalls until the queue is empty.
  logic byp_unused_c;
  assign byp_unused_c = ^byp_raddr_i;
  assign byp_hit_o    = '0;
  assign byp_data_o   = '0;
`endif

  a_hold_when_stalled: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((|commit_we_i) && !commit_ready_o) |=>
      ($stable(commit_we_i) && $stable(commit_waddr_i) && $stable(commit_wdata_i)));

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CNT_W'(DEPTH));

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    n_deq_c <= count_q);

endmodule
